// File: rtl/add16_sequencer.sv
// 16-bit add/subtract done as two passes through an external shared 8-bit adder.
// Latency: start accepted in IDLE, done pulses 3 cycles later; one op per 4 cycles, start ignored while busy.
module add16_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        op_sub,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic        busy,
    output logic        done,
    output logic [15:0] result,
    output logic        carry_out,
    output logic        zero,
    output logic        overflow,
    output logic [7:0]  add_a,
    output logic [7:0]  add_b,
    output logic        add_cin,
    input  logic [7:0]  add_sum,
    input  logic        add_cout
);

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic        sub_q, sub_d;
    logic        carry_q, carry_d;
    logic [7:0]  lo_q, lo_d;
    logic [15:0] result_q, result_d;
    logic        cout_q, cout_d;
    logic        zero_q, zero_d;
    logic        ovf_q, ovf_d;
    logic [15:0] b_eff;

    assign b_eff = sub_q ? ~b_q : b_q;

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        sub_d    = sub_q;
        carry_d  = carry_q;
        lo_d     = lo_q;
        result_d = result_q;
        cout_d   = cout_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        add_a    = 8'h00;
        add_b    = 8'h00;
        add_cin  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = op_a;
                    b_d     = op_b;
                    sub_d   = op_sub;
                    state_d = LOW;
                end
            end
            LOW: begin
                add_a   = a_q[7:0];
                add_b   = b_eff[7:0];
                add_cin = sub_q;
                lo_d    = add_sum;
                carry_d = add_cout;
                state_d = HIGH;
            end
            HIGH: begin
                // Low byte is staged in lo_q so the visible result changes only once per op.
                add_a    = a_q[15:8];
                add_b    = b_eff[15:8];
                add_cin  = carry_q;
                result_d = {add_sum, lo_q};
                cout_d   = add_cout;
                zero_d   = ({add_sum, lo_q} == 16'h0000);
                ovf_d    = (a_q[15] == b_eff[15]) && (add_sum[7] != a_q[15]);
                state_d  = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= 16'h0000;
            b_q      <= 16'h0000;
            sub_q    <= 1'b0;
            carry_q  <= 1'b0;
            lo_q     <= 8'h00;
            result_q <= 16'h0000;
            cout_q   <= 1'b0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            sub_q    <= sub_d;
            carry_q  <= carry_d;
            lo_q     <= lo_d;
            result_q <= result_d;
            cout_q   <= cout_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign result    = result_q;
    assign carry_out = cout_q;
    assign zero      = zero_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_add16_sequencer.sv
// Directed bench for add16_sequencer with a behavioural shared adder and a per-cycle
// monitor of the adder drive, busy and done against an independent state model.
module tb_add16_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        op_sub;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic        busy;
    logic        done;
    logic [15:0] result;
    logic        carry_out;
    logic        zero;
    logic        overflow;
    logic [7:0]  add_a;
    logic [7:0]  add_b;
    logic        add_cin;
    logic [7:0]  add_sum;
    logic        add_cout;

    int checks   = 0;
    int failures = 0;

    add16_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .op_sub    (op_sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out),
        .zero      (zero),
        .overflow  (overflow),
        .add_a     (add_a),
        .add_b     (add_b),
        .add_cin   (add_cin),
        .add_sum   (add_sum),
        .add_cout  (add_cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Shared 8-bit adder: purely combinational a + b + cin.
    logic [8:0] sum9;
    assign sum9     = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};
    assign add_sum  = sum9[7:0];
    assign add_cout = sum9[8];

    // Independent model of the sequencing: 0 idle, 1 low, 2 high, 3 done.
    logic [1:0]  m_state;
    logic [15:0] m_a, m_b;
    logic        m_sub;
    logic [15:0] m_beff;
    logic [8:0]  m_lo9;
    assign m_beff = m_sub ? ~m_b : m_b;
    assign m_lo9  = {1'b0, m_a[7:0]} + {1'b0, m_beff[7:0]} + {8'h00, m_sub};

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 2'd0;
        end else begin
            case (m_state)
                2'd0: if (start) begin
                    m_a     <= op_a;
                    m_b     <= op_b;
                    m_sub   <= op_sub;
                    m_state <= 2'd1;
                end
                2'd1: m_state <= 2'd2;
                2'd2: m_state <= 2'd3;
                default: m_state <= 2'd0;
            endcase
        end
    end

    always @(negedge clk) begin
        logic [7:0] ea, eb;
        logic       ec;
        ea = 8'h00; eb = 8'h00; ec = 1'b0;
        if (m_state == 2'd1) begin
            ea = m_a[7:0];  eb = m_beff[7:0];  ec = m_sub;
        end else if (m_state == 2'd2) begin
            ea = m_a[15:8]; eb = m_beff[15:8]; ec = m_lo9[8];
        end
        checks++;
        if ({add_a, add_b, add_cin} !== {ea, eb, ec}) begin
            failures++;
            $display("FAIL mon_adder_drive t=%0t state=%0d got a=%h b=%h cin=%b want a=%h b=%h cin=%b",
                     $time, m_state, add_a, add_b, add_cin, ea, eb, ec);
        end
        checks++;
        if ({busy, done} !== {m_state != 2'd0, m_state == 2'd3}) begin
            failures++;
            $display("FAIL mon_busy_done t=%0t state=%0d got busy=%b done=%b", $time, m_state, busy, done);
        end
    end

    // Stimulus helper: presents one start for one cycle and waits (bounded) for done.
    // Returns edges from the presenting edge to done, and the number of busy cycles seen.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic sub,
                         output int lat, output int busy_cyc);
        int n;
        @(posedge clk); #1;
        start = 1'b1; op_a = a; op_b = b; op_sub = sub;
        @(posedge clk); #1;
        start = 1'b0; op_a = 16'hDEAD; op_b = 16'hBEEF; op_sub = ~sub;
        n = 0; busy_cyc = 0;
        while (!done && n < 10) begin
            if (busy) busy_cyc++;
            @(posedge clk); #1;
            n++;
        end
        if (busy) busy_cyc++;
        lat = done ? n + 1 : -1;
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b0; op_sub = 1'b0; op_a = 16'h0; op_b = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, carry_out, zero, overflow} !== 21'h0) begin
            failures++;
            $display("FAIL reset_outputs got busy=%b done=%b result=%h c=%b z=%b v=%b want all 0",
                     busy, done, result, carry_out, zero, overflow);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 17'h0) begin
            failures++;
            $display("FAIL reset_adder_drive got a=%h b=%h cin=%b want 0", add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_add_basic;
        int lat, bc;
        do_op(16'h00FF, 16'h0001, 1'b0, lat, bc);
        checks++;
        if (lat !== 3) begin
            failures++;
            $display("FAIL add_basic_latency got %0d edges want 3", lat);
        end
        checks++;
        if (bc !== 3) begin
            failures++;
            $display("FAIL add_basic_busy_cycles got %0d want 3", bc);
        end
        checks++;
        if ({result, carry_out, zero, overflow} !== {16'h0100, 3'b000}) begin
            failures++;
            $display("FAIL add_basic_result got %h c=%b z=%b v=%b want 0100 c=0 z=0 v=0",
                     result, carry_out, zero, overflow);
        end
    endtask

    task automatic test_add_wrap;
        int lat, bc;
        do_op(16'hFFFF, 16'h0001, 1'b0, lat, bc);
        checks++;
        if ({result, carry_out, zero, overflow} !== {16'h0000, 3'b110}) begin
            failures++;
            $display("FAIL add_wrap_result got %h c=%b z=%b v=%b want 0000 c=1 z=1 v=0",
                     result, carry_out, zero, overflow);
        end
        do_op(16'h7FFF, 16'h0001, 1'b0, lat, bc);
        checks++;
        if ({result, carry_out, zero, overflow} !== {16'h8000, 3'b001}) begin
            failures++;
            $display("FAIL add_ovf_result got %h c=%b z=%b v=%b want 8000 c=0 z=0 v=1",
                     result, carry_out, zero, overflow);
        end
    endtask

    task automatic test_sub;
        int lat, bc;
        do_op(16'h8000, 16'h0001, 1'b1, lat, bc);
        checks++;
        if ({result, carry_out, zero, overflow} !== {16'h7FFF, 3'b101}) begin
            failures++;
            $display("FAIL sub_ovf_result got %h c=%b z=%b v=%b want 7FFF c=1 z=0 v=1",
                     result, carry_out, zero, overflow);
        end
        do_op(16'h0000, 16'h0001, 1'b1, lat, bc);
        checks++;
        if ({result, carry_out, zero, overflow} !== {16'hFFFF, 3'b000}) begin
            failures++;
            $display("FAIL sub_borrow_result got %h c=%b z=%b v=%b want FFFF c=0 z=0 v=0",
                     result, carry_out, zero, overflow);
        end
    endtask

    task automatic test_ignore_start;
        int pulses;
        pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = 16'h1000; op_b = 16'h0234; op_sub = 1'b0;
        @(posedge clk); #1;
        // Keep start high with different operands through LOW, HIGH and DONE.
        op_a = 16'hFFFF; op_b = 16'hFFFF; op_sub = 1'b1;
        for (int i = 0; i < 3; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (done) pulses++;
            @(posedge clk); #1;
        end
        checks++;
        if (pulses !== 1) begin
            failures++;
            $display("FAIL ignore_start_pulses got %0d done pulses want 1", pulses);
        end
        checks++;
        if (result !== 16'h1234) begin
            failures++;
            $display("FAIL ignore_start_result got %h want 1234", result);
        end
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_start_idle got busy=%b want 0", busy);
        end
    endtask

    task automatic test_back_to_back;
        int lat, bc;
        do_op(16'h0001, 16'h0002, 1'b0, lat, bc);
        @(posedge clk); #1;
        start = 1'b1; op_a = 16'h4000; op_b = 16'h0100; op_sub = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checks++;
        if ({busy, result} !== {1'b1, 16'h0003}) begin
            failures++;
            $display("FAIL b2b_accept_hold got busy=%b result=%h want busy=1 result=0003", busy, result);
        end
        @(posedge clk); #1;
        checks++;
        if (result !== 16'h0003) begin
            failures++;
            $display("FAIL b2b_hold_in_high got %h want 0003", result);
        end
        @(posedge clk); #1;
        checks++;
        if ({done, result, carry_out, overflow} !== {1'b1, 16'h3F00, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second_result got done=%b %h c=%b v=%b want done=1 3F00 c=1 v=0",
                     done, result, carry_out, overflow);
        end
    endtask

    task automatic test_reset_mid;
        int lat, bc, pulses;
        pulses = 0;
        @(posedge clk); #1;
        start = 1'b1; op_a = 16'hAAAA; op_b = 16'h5555; op_sub = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (add_a !== 8'hAA) begin
            failures++;
            $display("FAIL reset_mid_in_high got add_a=%h want AA", add_a);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, carry_out, zero, overflow, add_a, add_b, add_cin} !== 38'h0) begin
            failures++;
            $display("FAIL reset_mid_outputs got busy=%b done=%b r=%h c=%b z=%b v=%b a=%h b=%h cin=%b want 0",
                     busy, done, result, carry_out, zero, overflow, add_a, add_b, add_cin);
        end
        #2 rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (done) pulses++;
        end
        checks++;
        if (pulses !== 0) begin
            failures++;
            $display("FAIL reset_mid_no_done got %0d done pulses want 0", pulses);
        end
        do_op(16'h1234, 16'h1111, 1'b0, lat, bc);
        checks++;
        if ({lat, result} !== {32'd3, 16'h2345}) begin
            failures++;
            $display("FAIL reset_mid_recover got lat=%0d result=%h want lat=3 result=2345", lat, result);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_basic();
        test_add_wrap();
        test_sub();
        test_ignore_start();
        test_back_to_back();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
